// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one external adder among NUM_REQ
// requesters. Two registered stages: operands out, then tagged sum back.
// Ports: clk_i, reset_i (sync, active-high)
//   req_valid_i/req_ready_o, req_a_i/req_b_i : packed requester side
//   add_a_o/add_b_o/add_sum_i                : external adder
//   rsp_valid_o/rsp_ready_i, rsp_id_o/rsp_sum_o : tagged response
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_b_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [WIDTH-1:0]              add_a_o,
  output logic [WIDTH-1:0]              add_b_o,
  input  logic [WIDTH:0]                add_sum_i,
  output logic                          rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
  output logic [WIDTH:0]                rsp_sum_o,
  input  logic                          rsp_ready_i
);

  localparam int IDW = $clog2(NUM_REQ);

  logic             op_valid_q, op_valid_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             rv_q, rv_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic [WIDTH:0]   rsum_q, rsum_d;
  logic [IDW-1:0]   last_q, last_d;

  logic             s2_free, s1_free;
  logic             grant_vld, hs;
  logic [IDW-1:0]   grant_id;
  int               idx;

  assign s2_free = !rv_q || rsp_ready_i;
  assign s1_free = !op_valid_q || s2_free;

  // Search starts one past the last winner and wraps.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && req_valid_i[idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign hs = grant_vld && s1_free && !reset_i;

  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = hs && (grant_id == IDW'(k));
    end
  end

  always_comb begin
    op_valid_d = op_valid_q;
    op_id_d    = op_id_q;
    a_d        = a_q;
    b_d        = b_q;
    last_d     = last_q;
    rv_d       = rv_q;
    rid_d      = rid_q;
    rsum_d     = rsum_q;
    if (hs) begin
      op_valid_d = 1'b1;
      op_id_d    = grant_id;
      a_d        = req_a_i[grant_id*WIDTH +: WIDTH];
      b_d        = req_b_i[grant_id*WIDTH +: WIDTH];
      last_d     = grant_id;
    end else if (s1_free) begin
      op_valid_d = 1'b0;
    end
    // A new load takes priority over a pop so a full pipe streams.
    if (op_valid_q && s2_free) begin
      rv_d   = 1'b1;
      rid_d  = op_id_q;
      rsum_d = add_sum_i;
    end else if (rv_q && rsp_ready_i) begin
      rv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_valid_q <= 1'b0;
      op_id_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      last_q     <= IDW'(NUM_REQ - 1);
      rv_q       <= 1'b0;
      rid_q      <= '0;
      rsum_q     <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_id_q    <= op_id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      last_q     <= last_d;
      rv_q       <= rv_d;
      rid_q      <= rid_d;
      rsum_q     <= rsum_d;
    end
  end

  assign add_a_o     = a_q;
  assign add_b_o     = b_q;
  assign rsp_valid_o = rv_q;
  assign rsp_id_o    = rid_q;
  assign rsp_sum_o   = rsum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed stimulus with a response scoreboard.
// The external adder is modelled here as a plain combinational add.
module tb_adder_arbiter;

  logic        clk;
  logic        reset_i;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready_o;
  logic [3:0]  add_a_o, add_b_o;
  logic [4:0]  add_sum;
  logic        rsp_valid_o;
  logic [1:0]  rsp_id_o;
  logic [4:0]  rsp_sum_o;
  logic        rsp_ready;

  int checks = 0;
  int errors = 0;
  logic [6:0] sb[$];

  adder_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .req_valid_i(req_valid),
    .req_a_i(req_a),
    .req_b_i(req_b),
    .req_ready_o(req_ready_o),
    .add_a_o(add_a_o),
    .add_b_o(add_b_o),
    .add_sum_i(add_sum),
    .rsp_valid_o(rsp_valid_o),
    .rsp_id_o(rsp_id_o),
    .rsp_sum_o(rsp_sum_o),
    .rsp_ready_i(rsp_ready)
  );

  assign add_sum = {1'b0, add_a_o} + {1'b0, add_b_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop on every response handshake.
  always @(negedge clk) begin
    if (!reset_i && rsp_valid_o && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_extra got id=%0d sum=%0d expected none",
                 rsp_id_o, rsp_sum_o);
      end else begin
        logic [6:0] e;
        e = sb.pop_front();
        if (e != {rsp_id_o, rsp_sum_o}) begin
          errors++;
          $display("FAIL rsp got id=%0d sum=%0d expected id=%0d sum=%0d",
                   rsp_id_o, rsp_sum_o, e[6:5], e[4:0]);
        end
      end
    end
  end

  // One cycle: drive, check grant (and optionally rsp_valid), push.
  task automatic step(input logic [3:0] v, input logic [15:0] a,
                      input logic [15:0] b, input logic rr,
                      input logic [3:0] er, input int erv,
                      input string nm);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    @(negedge clk);
    chk({nm, "_rdy"}, int'(req_ready_o), int'(er));
    if (erv >= 0) chk({nm, "_rv"}, int'(rsp_valid_o), erv);
    for (int k = 0; k < 4; k++) begin
      if (er[k]) begin
        logic [1:0] id;
        logic [4:0] s;
        id = k[1:0];
        s  = {1'b0, a[k*4 +: 4]} + {1'b0, b[k*4 +: 4]};
        sb.push_back({id, s});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v, input string nm);
    reset_i   = 1'b1;
    req_valid = v;
    rsp_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    chk({nm, "_rdy"}, int'(req_ready_o), 0);
    @(posedge clk);
    #1;
    chk({nm, "_rv"}, int'(rsp_valid_o), 0);
    chk({nm, "_rid"}, int'(rsp_id_o), 0);
    chk({nm, "_rsum"}, int'(rsp_sum_o), 0);
    chk({nm, "_adda"}, int'(add_a_o), 0);
    chk({nm, "_addb"}, int'(add_b_o), 0);
    reset_i   = 1'b0;
    rsp_ready = 1'b1;
  endtask

  localparam logic [15:0] AK  = 16'h3210;
  localparam logic [15:0] BK  = 16'h4321;
  localparam logic [15:0] A1  = 16'h0900;
  localparam logic [15:0] B1  = 16'h0800;
  localparam logic [15:0] AOV = 16'h000F;

  initial begin
    reset_i   = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    do_reset(4'b0000, "init");

    // single request from requester 2: 9+8
    step(4'b0100, A1, B1, 1'b1, 4'b0100, 0, "s1_t0");
    step(4'b0000, A1, B1, 1'b1, 4'b0000, 0, "s1_t1");
    step(4'b0000, A1, B1, 1'b1, 4'b0000, 1, "s1_t2");
    step(4'b0000, A1, B1, 1'b1, 4'b0000, 0, "s1_t3");

    // all four streaming from a fresh priority
    do_reset(4'b0000, "rst2");
    step(4'b1111, AK, BK, 1'b1, 4'b0001, 0, "rr_g0");
    step(4'b1111, AK, BK, 1'b1, 4'b0010, 0, "rr_g1");
    step(4'b1111, AK, BK, 1'b1, 4'b0100, 1, "rr_g2");
    step(4'b1111, AK, BK, 1'b1, 4'b1000, 1, "rr_g3");
    step(4'b1111, AK, BK, 1'b1, 4'b0001, 1, "rr_g4");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 1, "rr_d1");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 1, "rr_d2");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 0, "rr_d3");

    // fairness between 0 and 3; 15+15 and 0+0
    step(4'b1001, AOV, AOV, 1'b1, 4'b1000, 0, "fa_g0");
    step(4'b1001, AOV, AOV, 1'b1, 4'b0001, 0, "fa_g1");
    step(4'b1001, AOV, AOV, 1'b1, 4'b1000, 1, "fa_g2");
    step(4'b1001, AOV, AOV, 1'b1, 4'b0001, 1, "fa_g3");
    step(4'b0000, AOV, AOV, 1'b1, 4'b0000, 1, "fa_d1");
    step(4'b0000, AOV, AOV, 1'b1, 4'b0000, 1, "fa_d2");

    // backpressure
    step(4'b1111, AK, BK, 1'b0, 4'b0010, 0, "bp_c1");
    step(4'b1111, AK, BK, 1'b0, 4'b0100, 0, "bp_c2");
    step(4'b1111, AK, BK, 1'b0, 4'b0000, 1, "bp_c3");
    chk("bp_hold_id", int'(rsp_id_o), 1);
    chk("bp_hold_sum", int'(rsp_sum_o), 3);
    chk("bp_hold_adda", int'(add_a_o), 2);
    step(4'b1111, AK, BK, 1'b0, 4'b0000, 1, "bp_c4");
    chk("bp_hold2_id", int'(rsp_id_o), 1);
    chk("bp_hold2_sum", int'(rsp_sum_o), 3);
    step(4'b1111, AK, BK, 1'b1, 4'b1000, 1, "bp_c5");
    step(4'b1111, AK, BK, 1'b1, 4'b0001, 1, "bp_c6");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 1, "bp_c7");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 1, "bp_c8");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 0, "bp_c9");

    // reset with both stages full
    step(4'b1111, AK, BK, 1'b0, 4'b0010, 0, "mr_c1");
    step(4'b1111, AK, BK, 1'b0, 4'b0100, 0, "mr_c2");
    do_reset(4'b1111, "mr_rst");
    step(4'b1111, AK, BK, 1'b1, 4'b0001, 0, "mr_g0");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 0, "mr_d1");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 1, "mr_d2");
    step(4'b0000, AK, BK, 1'b1, 4'b0000, 0, "mr_d3");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
